// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared torus NoC constants: flit layout, default link
//                timing, receive buffering and a constant clog2 helper.
//  Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

  localparam int FLIT_WIDTH         = 256;
  localparam int FLIT_VALID_BIT     = FLIT_WIDTH - 1;
  localparam int LINK_DELAY         = 20;
  localparam int RX_FIFO_DEPTH      = 128;
  localparam int UTIL_WINDOW_CYCLES = 256;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/link_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : link_delay_line
//  Description : Fixed-latency registered shift pipeline of DELAY stages.
//                Input captured at edge E appears on data_out after edge
//                E+DELAY-1, so a consumer sampling it lands at E+DELAY.
//  Revision    : 1.0  initial release
// ============================================================================
module link_delay_line #(
  parameter int W     = 1,
  parameter int DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  logic [W-1:0] pipe_q [DELAY];
  logic [W-1:0] pipe_d [DELAY];

  // Next stage contents: shift everything one stage toward the output.
  always_comb begin
    pipe_d[0] = data_in;
    for (int i = 1; i < DELAY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers; reset flushes everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign data_out = pipe_q[DELAY-1];

endmodule
`default_nettype wire

// File: rtl/torus_link_channel.sv
`default_nettype none
// ============================================================================
//  Module      : torus_link_channel
//  Description : Credit-flow-controlled directed torus link. Forward flits
//                and reverse credits each cross a DELAY-cycle pipe; flits
//                land in a receive FIFO whose depth equals the initial
//                credit count, so the link never loses a flit.
//  Revision    : 1.0  initial release
// ============================================================================
module torus_link_channel
  import noc_pkg::*;
#(
  parameter int WIDTH       = FLIT_WIDTH,
  parameter int DELAY       = LINK_DELAY,
  parameter int FIFO_DEPTH  = RX_FIFO_DEPTH,
  parameter int CW          = clog2(FIFO_DEPTH + 1),
  parameter int UTIL_WINDOW = UTIL_WINDOW_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_pop,
  output logic [CW-1:0]    credits,
  output logic [7:0]       util,
  output logic             drop_err,
  output logic             ovf_err
);

  localparam int              c_vbit     = WIDTH - 1;
  localparam int              c_pw       = (FIFO_DEPTH > 1) ? clog2(FIFO_DEPTH) : 1;
  localparam int              c_ww       = (UTIL_WINDOW > 1) ? clog2(UTIL_WINDOW) : 1;
  localparam logic [CW-1:0]   c_depth    = CW'(FIFO_DEPTH);
  localparam logic [c_pw-1:0] c_ptr_last = c_pw'(FIFO_DEPTH - 1);
  localparam logic [c_ww-1:0] c_win_last = c_ww'(UTIL_WINDOW - 1);

  // Handshake / datapath wires
  logic             tx_valid;
  logic             accept;
  logic [WIDTH-1:0] fwd_in;
  logic [WIDTH-1:0] fwd_out;
  logic             arrive;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             credit_ret;
  logic [7:0]       acc_sat;

  // State
  logic [CW-1:0]    credits_q,  credits_d;
  logic [c_pw-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [c_pw-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]    count_q,    count_d;
  logic [c_ww-1:0]  win_q,      win_d;
  logic [7:0]       acc_q,      acc_d;
  logic [7:0]       util_q,     util_d;
  logic             drop_err_q, drop_err_d;
  logic             ovf_err_q,  ovf_err_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Sender side: readiness comes only from the credit register.
  always_comb begin
    tx_valid = tx_data[c_vbit];
    tx_ready = (credits_q != '0);
    accept   = tx_valid & tx_ready;
    fwd_in   = accept ? tx_data : '0;
  end

  link_delay_line #(.W(WIDTH), .DELAY(DELAY)) u_fwd_pipe (
    .clk      (clk),
    .rst      (rst),
    .data_in  (fwd_in),
    .data_out (fwd_out)
  );

  link_delay_line #(.W(1), .DELAY(DELAY)) u_credit_pipe (
    .clk      (clk),
    .rst      (rst),
    .data_in  (pop),
    .data_out (credit_ret)
  );

  // Receive FIFO control: a pop frees the slot an arrival may use on the same edge.
  always_comb begin
    arrive   = fwd_out[c_vbit];
    full     = (count_q == c_depth);
    pop      = rx_pop & (count_q != '0);
    wr_en    = arrive & (~full | pop);
    rd_ptr_d = pop   ? ((rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + c_pw'(1)) : rd_ptr_q;
    wr_ptr_d = wr_en ? ((wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + c_pw'(1)) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    rx_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

  // Credit counter: accept and return on the same edge cancel out.
  always_comb begin
    credits_d = credits_q;
    if (accept && !credit_ret) begin
      credits_d = credits_q - CW'(1);
    end else if (!accept && credit_ret && (credits_q != c_depth)) begin
      credits_d = credits_q + CW'(1);
    end
  end

  // Utilisation window: the closing cycle's accept is folded into the report.
  always_comb begin
    acc_sat = (acc_q == 8'hFF) ? acc_q : acc_q + {7'd0, accept};
    util_d  = util_q;
    if (win_q == c_win_last) begin
      win_d  = '0;
      acc_d  = '0;
      util_d = acc_sat;
    end else begin
      win_d  = win_q + c_ww'(1);
      acc_d  = acc_sat;
    end
  end

  // Sticky protocol error flags.
  always_comb begin
    drop_err_d = drop_err_q | (tx_valid & ~tx_ready);
    ovf_err_d  = ovf_err_q  | (arrive & full & ~pop);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q  <= c_depth;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      util_q     <= '0;
      drop_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      util_q     <= util_d;
      drop_err_q <= drop_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  // FIFO storage; contents are only visible while occupancy says so, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= fwd_out;
  end

  assign credits  = credits_q;
  assign util     = util_q;
  assign drop_err = drop_err_q;
  assign ovf_err  = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_torus_link_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_torus_link_channel
//  Description : Directed self-checking bench for torus_link_channel at the
//                default parameters (WIDTH 256, DELAY 20, depth 128).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_torus_link_channel;

  logic         clk;
  logic         rst;
  logic [255:0] tx_data;
  logic         tx_ready;
  logic [255:0] rx_data;
  logic         rx_pop;
  logic [7:0]   credits;
  logic [7:0]   util;
  logic         drop_err;
  logic         ovf_err;

  int n_vec;
  int n_err;

  torus_link_channel dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_pop   (rx_pop),
    .credits  (credits),
    .util     (util),
    .drop_err (drop_err),
    .ovf_err  (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, recognisable valid flit for index i.
  function automatic logic [255:0] mkflit(input int i);
    logic [254:0] p;
    p = 255'(i) | (255'(i) << 128) | (255'h1 << 200);
    return {1'b1, p};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; tx_data = '0; rx_pop = 1'b0;
    tick(3);
    n_vec++; if (credits !== 8'd128) begin n_err++; $display("FAIL reset_credits: got %0d expected 128", credits); end
    n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %0b expected 1", tx_ready); end
    n_vec++; if (rx_data !== 256'h0) begin n_err++; $display("FAIL reset_rx_data: got %0h expected 0", rx_data); end
    n_vec++; if (util !== 8'd0) begin n_err++; $display("FAIL reset_util: got %0d expected 0", util); end
    n_vec++; if ({drop_err, ovf_err} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b expected 00", {drop_err, ovf_err}); end
    rst = 1'b1;
    tick(2);
    n_vec++; if (credits !== 8'd128 || tx_ready !== 1'b1) begin n_err++; $display("FAIL idle_credits: got %0d/%0b expected 128/1", credits, tx_ready); end
  endtask

  task automatic test_single();
    logic [255:0] f;
    f = {1'b1, 255'h0A5};
    tx_data = f;
    tick(1);                               // accept edge E0
    tx_data = '0;
    n_vec++; if (credits !== 8'd127) begin n_err++; $display("FAIL single_credit_dec: got %0d expected 127", credits); end
    tick(19);                              // E0+19
    n_vec++; if (rx_data !== 256'h0) begin n_err++; $display("FAIL single_early: got %0h expected 0", rx_data); end
    tick(1);                               // E0+20
    n_vec++; if (rx_data !== f) begin n_err++; $display("FAIL single_arrive: got %0h expected %0h", rx_data, f); end
    rx_pop = 1'b1;
    tick(1);                               // pop edge P
    rx_pop = 1'b0;
    n_vec++; if (rx_data !== 256'h0) begin n_err++; $display("FAIL single_popped: got %0h expected 0", rx_data); end
    tick(19);                              // P+19
    n_vec++; if (credits !== 8'd127) begin n_err++; $display("FAIL single_credit_early: got %0d expected 127", credits); end
    tick(1);                               // P+20
    n_vec++; if (credits !== 8'd128) begin n_err++; $display("FAIL single_credit_ret: got %0d expected 128", credits); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 129; i++) begin
      tx_data = mkflit(i);
      tick(1);
      if (i == 127) begin
        n_vec++; if (credits !== 8'd0 || tx_ready !== 1'b0) begin n_err++; $display("FAIL bp_exhausted: got %0d/%0b expected 0/0", credits, tx_ready); end
        n_vec++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL bp_no_drop_yet: got %0b expected 0", drop_err); end
      end
    end
    tx_data = '0;
    n_vec++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL bp_drop_err: got %0b expected 1", drop_err); end
    tick(20);
    n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL bp_ovf_err: got %0b expected 0", ovf_err); end
    n_vec++; if (rx_data !== mkflit(0)) begin n_err++; $display("FAIL bp_head: got %0h expected %0h", rx_data, mkflit(0)); end
  endtask

  task automatic test_credit_return();
    rx_pop = 1'b1;
    tick(1);                               // pop edge c
    rx_pop = 1'b0;
    tick(19);
    n_vec++; if (credits !== 8'd0) begin n_err++; $display("FAIL cr_early: got %0d expected 0", credits); end
    tick(1);                               // c+20
    n_vec++; if (credits !== 8'd1 || tx_ready !== 1'b1) begin n_err++; $display("FAIL cr_return: got %0d/%0b expected 1/1", credits, tx_ready); end
    for (int j = 1; j < 128; j++) begin
      n_vec++; if (rx_data !== mkflit(j)) begin n_err++; $display("FAIL drain_order[%0d]: got %0h expected %0h", j, rx_data, mkflit(j)); end
      rx_pop = 1'b1;
      tick(1);
    end
    rx_pop = 1'b0;
    n_vec++; if (rx_data !== 256'h0) begin n_err++; $display("FAIL drain_empty: got %0h expected 0", rx_data); end
    n_vec++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL drain_ovf: got %0b expected 0", ovf_err); end
    tick(20);
    n_vec++; if (credits !== 8'd128) begin n_err++; $display("FAIL drain_credits: got %0d expected 128", credits); end
  endtask

  task automatic test_simultaneous();
    tx_data = mkflit(500);
    tick(1);                               // A
    tx_data = '0;
    tick(20);                              // A+20: landed
    rx_pop = 1'b1;
    tick(1);                               // A+21: pop, credit back at A+41
    rx_pop = 1'b0;
    tick(19);                              // A+40
    n_vec++; if (credits !== 8'd127) begin n_err++; $display("FAIL sim_before: got %0d expected 127", credits); end
    tx_data = mkflit(501);
    tick(1);                               // A+41: accept and return together
    tx_data = '0;
    n_vec++; if (credits !== 8'd127) begin n_err++; $display("FAIL sim_unchanged: got %0d expected 127", credits); end
    rx_pop = 1'b1;
    tick(1);                               // pop while FIFO empty
    rx_pop = 1'b0;
    tick(24);
    n_vec++; if (credits !== 8'd127) begin n_err++; $display("FAIL empty_pop_credit: got %0d expected 127", credits); end
    n_vec++; if (rx_data !== mkflit(501)) begin n_err++; $display("FAIL empty_pop_fifo: got %0h expected %0h", rx_data, mkflit(501)); end
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
    tick(20);
    n_vec++; if (credits !== 8'd128) begin n_err++; $display("FAIL sim_final: got %0d expected 128", credits); end
  endtask

  task automatic test_util();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    for (int e = 1; e <= 256; e++) begin
      tx_data = (e <= 99 || e == 256) ? mkflit(1000 + e) : '0;
      tick(1);
      if (e == 255) begin
        n_vec++; if (util !== 8'd0) begin n_err++; $display("FAIL util_before_end: got %0d expected 0", util); end
      end
    end
    tx_data = '0;
    n_vec++; if (util !== 8'd100) begin n_err++; $display("FAIL util_window: got %0d expected 100", util); end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 5; i++) begin
      tx_data = mkflit(2000 + i);
      tick(1);
    end
    tx_data = '0;
    tick(3);
    rst = 1'b0;
    #1;
    n_vec++; if (credits !== 8'd128 || tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_fly_credits: got %0d/%0b expected 128/1", credits, tx_ready); end
    n_vec++; if (rx_data !== 256'h0) begin n_err++; $display("FAIL rst_fly_rx: got %0h expected 0", rx_data); end
    n_vec++; if (util !== 8'd0) begin n_err++; $display("FAIL rst_fly_util: got %0d expected 0", util); end
    n_vec++; if ({drop_err, ovf_err} !== 2'b00) begin n_err++; $display("FAIL rst_fly_errs: got %b expected 00", {drop_err, ovf_err}); end
    tick(3);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      n_vec++; if (rx_data !== 256'h0) begin n_err++; $display("FAIL rst_fly_ghost[%0d]: got %0h expected 0", k, rx_data); end
    end
    n_vec++; if (credits !== 8'd128) begin n_err++; $display("FAIL rst_fly_final: got %0d expected 128", credits); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    tx_data = '0;
    rx_pop = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_credit_return();
    test_simultaneous();
    test_util();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
